// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bus: fetch/writeback inputs and the registered ID/EX outputs.
// master drives the fetch/writeback side; slave is the decode stage itself.
interface decode_stage_pipe_if #(
   parameter int DATA_W = 32,
   parameter int AW     = 5
);
   logic              id_valid;
   logic [31:0]       instruccion;
   logic              flush;
   logic              wb_reg_write;
   logic [AW-1:0]     wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              stall;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_data1;
   logic [DATA_W-1:0] ex_data2;
   logic [DATA_W-1:0] ex_imm;
   logic [AW-1:0]     ex_rs;
   logic [AW-1:0]     ex_rt;
   logic [AW-1:0]     ex_rd;
   logic              ex_branch;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic              ex_mem_to_reg;
   logic              ex_reg_dst;
   logic              ex_reg_write;
   logic              ex_alu_src;
   logic [5:0]        ex_alu_op;
   logic              ex_illegal;

   // Handshake: id_valid qualifies instruccion; while stall is high the
   // producer must hold instruccion unchanged, it is taken on the first
   // rising edge with stall low (or dropped on flush).
   modport master (
      output id_valid, instruccion, flush, wb_reg_write, wb_addr, wb_data,
      input  stall, ex_valid, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_rd,
             ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_dst,
             ex_reg_write, ex_alu_src, ex_alu_op, ex_illegal
   );

   modport slave (
      input  id_valid, instruccion, flush, wb_reg_write, wb_addr, wb_data,
      output stall, ex_valid, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_rd,
             ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_dst,
             ex_reg_write, ex_alu_src, ex_alu_op, ex_illegal
   );
endinterface

// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with write-through bypass, immediate extension,
// load-use stall and flush, feeding a registered ID/EX stage.
module decode_stage_pipe #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int IMM_W  = 16
) (
   input logic                clk,
   input logic                rst_n,
   decode_stage_pipe_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data1;
      logic [DATA_W-1:0] data2;
      logic [DATA_W-1:0] imm;
      logic [AW-1:0]     rs;
      logic [AW-1:0]     rt;
      logic [AW-1:0]     rd;
      logic              branch;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
      logic              reg_dst;
      logic              reg_write;
      logic              alu_src;
      logic [5:0]        alu_op;
      logic              illegal;
   } ex_t;

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [AW-1:0]     rs;
   logic [AW-1:0]     rt;
   logic [AW-1:0]     rd;
   logic [IMM_W-1:0]  imm_raw;
   logic              wr_en;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              zero_ext;
   logic              rt_src;
   logic              hazard;
   logic              bubble;
   logic              unused;
   logic [DATA_W-1:0] regs [NREGS];
   ex_t               ex_d;
   ex_t               ex_q;

   assign opcode  = bus.instruccion[31:26];
   assign funct   = bus.instruccion[5:0];
   assign rs      = bus.instruccion[21 +: AW];
   assign rt      = bus.instruccion[16 +: AW];
   assign rd      = bus.instruccion[11 +: AW];
   assign imm_raw = bus.instruccion[IMM_W-1:0];
   assign unused  = ^bus.instruccion;

   assign wr_en = bus.wb_reg_write && (bus.wb_addr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   // Write-through: a same-cycle writeback is visible to the reader.
   always_comb begin
      rd1 = regs[rs];
      if (rs == '0) rd1 = '0;
      else if (wr_en && (bus.wb_addr == rs)) rd1 = bus.wb_data;
      rd2 = regs[rt];
      if (rt == '0) rd2 = '0;
      else if (wr_en && (bus.wb_addr == rt)) rd2 = bus.wb_data;
   end

   always_comb begin
      ex_d       = '0;
      zero_ext   = 1'b0;
      rt_src     = 1'b0;
      ex_d.valid = 1'b1;
      ex_d.rs    = rs;
      ex_d.rt    = rt;
      ex_d.rd    = rd;
      ex_d.data1 = rd1;
      ex_d.data2 = rd2;
      case (opcode)
         6'h00: begin
            ex_d.reg_dst   = 1'b1;
            ex_d.reg_write = 1'b1;
            ex_d.alu_op    = funct;
            rt_src         = 1'b1;
         end
         6'h23: begin
            ex_d.mem_read   = 1'b1;
            ex_d.mem_to_reg = 1'b1;
            ex_d.reg_write  = 1'b1;
            ex_d.alu_src    = 1'b1;
            ex_d.alu_op     = 6'h20;
         end
         6'h2B: begin
            ex_d.mem_write = 1'b1;
            ex_d.alu_src   = 1'b1;
            ex_d.alu_op    = 6'h20;
            rt_src         = 1'b1;
         end
         6'h04: begin
            ex_d.branch = 1'b1;
            ex_d.alu_op = 6'h22;
            rt_src      = 1'b1;
         end
         6'h08: begin
            ex_d.reg_write = 1'b1;
            ex_d.alu_src   = 1'b1;
            ex_d.alu_op    = 6'h20;
         end
         6'h0C: begin
            ex_d.reg_write = 1'b1;
            ex_d.alu_src   = 1'b1;
            ex_d.alu_op    = 6'h24;
            zero_ext       = 1'b1;
         end
         6'h0D: begin
            ex_d.reg_write = 1'b1;
            ex_d.alu_src   = 1'b1;
            ex_d.alu_op    = 6'h25;
            zero_ext       = 1'b1;
         end
         default: ex_d.illegal = 1'b1;
      endcase
      ex_d.imm = zero_ext ? DATA_W'(imm_raw) : DATA_W'($signed(imm_raw));
   end

   // A load in EX whose destination this instruction reads: hold one cycle.
   assign hazard = bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rt != '0) &&
                   ((ex_q.rt == rs) || (rt_src && (ex_q.rt == rt)));
   assign bus.stall = hazard && !bus.flush;
   assign bubble    = bus.flush || hazard || !bus.id_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ex_q <= '0;
      else if (bubble) ex_q <= '0;
      else             ex_q <= ex_d;
   end

   assign bus.ex_valid      = ex_q.valid;
   assign bus.ex_data1      = ex_q.data1;
   assign bus.ex_data2      = ex_q.data2;
   assign bus.ex_imm        = ex_q.imm;
   assign bus.ex_rs         = ex_q.rs;
   assign bus.ex_rt         = ex_q.rt;
   assign bus.ex_rd         = ex_q.rd;
   assign bus.ex_branch     = ex_q.branch;
   assign bus.ex_mem_read   = ex_q.mem_read;
   assign bus.ex_mem_write  = ex_q.mem_write;
   assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
   assign bus.ex_reg_dst    = ex_q.reg_dst;
   assign bus.ex_reg_write  = ex_q.reg_write;
   assign bus.ex_alu_src    = ex_q.alu_src;
   assign bus.ex_alu_op     = ex_q.alu_op;
   assign bus.ex_illegal    = ex_q.illegal;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: a 32-bit/32-register and a 16-bit/8-register
// instance share one directed stimulus stream and are checked against a model.
module tb_decode_stage_pipe;
   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic        flush;
   logic        wbw;
   logic [31:0] instr;
   logic [31:0] wbd;
   logic [4:0]  wba;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          nst;

   decode_stage_pipe_if #(.DATA_W(32), .AW(5)) b32 ();
   decode_stage_pipe_if #(.DATA_W(16), .AW(3)) b16 ();

   assign b32.id_valid     = id_valid;
   assign b32.instruccion  = instr;
   assign b32.flush        = flush;
   assign b32.wb_reg_write = wbw;
   assign b32.wb_addr      = wba;
   assign b32.wb_data      = wbd;
   assign b16.id_valid     = id_valid;
   assign b16.instruccion  = instr;
   assign b16.flush        = flush;
   assign b16.wb_reg_write = wbw;
   assign b16.wb_addr      = wba[2:0];
   assign b16.wb_data      = wbd[15:0];

   decode_stage_pipe #(.DATA_W(32), .NREGS(32), .IMM_W(16)) dut32 (
      .clk(clk), .rst_n(rst_n), .bus(b32.slave));
   decode_stage_pipe #(.DATA_W(16), .NREGS(8), .IMM_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(b16.slave));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   typedef struct {
      logic        valid;
      logic [31:0] d1, d2, imm;
      logic [4:0]  rs, rt, rd;
      logic        br, mr, mw, m2r, rdst, rw, asrc;
      logic [5:0]  op;
      logic        ill;
   } ex_t;

   ex_t         m_ex [2];
   logic [31:0] m_regs [2][32];
   ex_t         got [2];
   logic        got_stall [2];

   function automatic logic [31:0] dmask(input int k);
      return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
   endfunction

   function automatic logic [4:0] amask(input int k);
      return (k == 0) ? 5'h1F : 5'h07;
   endfunction

   function automatic logic m_hazard(input int k);
      logic [4:0] rs, rt;
      logic [5:0] op;
      logic       uses_rt;
      op = instr[31:26];
      rs = instr[25:21] & amask(k);
      rt = instr[20:16] & amask(k);
      uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
      return id_valid && m_ex[k].valid && m_ex[k].mr && (m_ex[k].rt != 5'd0) &&
             ((m_ex[k].rt == rs) || (uses_rt && (m_ex[k].rt == rt)));
   endfunction

   function automatic logic [31:0] m_read(input int k, input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wbw && ((wba & amask(k)) == a)) return wbd & dmask(k);
      return m_regs[k][a];
   endfunction

   function automatic ex_t m_next(input int k);
      ex_t        e;
      logic [5:0] op;
      logic [15:0] imm;
      e = '{default: '0};
      if (!id_valid || flush || m_hazard(k)) return e;
      op      = instr[31:26];
      imm     = instr[15:0];
      e.valid = 1'b1;
      e.rs    = instr[25:21] & amask(k);
      e.rt    = instr[20:16] & amask(k);
      e.rd    = instr[15:11] & amask(k);
      e.d1    = m_read(k, e.rs);
      e.d2    = m_read(k, e.rt);
      e.imm   = ((op == 6'h0C) || (op == 6'h0D)) ? {16'h0, imm}
                                                 : ({{16{imm[15]}}, imm} & dmask(k));
      case (op)
         6'h00: begin e.rdst = 1; e.rw = 1; e.op = instr[5:0]; end
         6'h23: begin e.mr = 1; e.m2r = 1; e.rw = 1; e.asrc = 1; e.op = 6'h20; end
         6'h2B: begin e.mw = 1; e.asrc = 1; e.op = 6'h20; end
         6'h04: begin e.br = 1; e.op = 6'h22; end
         6'h08: begin e.rw = 1; e.asrc = 1; e.op = 6'h20; end
         6'h0C: begin e.rw = 1; e.asrc = 1; e.op = 6'h24; end
         6'h0D: begin e.rw = 1; e.asrc = 1; e.op = 6'h25; end
         default: e.ill = 1;
      endcase
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_ex[k] <= '{default: '0};
            for (int r = 0; r < 32; r++) m_regs[k][r] <= 32'd0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_ex[k] <= m_next(k);
            if (wbw && ((wba & amask(k)) != 5'd0))
               m_regs[k][wba & amask(k)] <= wbd & dmask(k);
         end
      end
   end

   always_comb begin
      got[0].valid = b32.ex_valid;        got[1].valid = b16.ex_valid;
      got[0].d1    = b32.ex_data1;        got[1].d1    = {16'h0, b16.ex_data1};
      got[0].d2    = b32.ex_data2;        got[1].d2    = {16'h0, b16.ex_data2};
      got[0].imm   = b32.ex_imm;          got[1].imm   = {16'h0, b16.ex_imm};
      got[0].rs    = b32.ex_rs;           got[1].rs    = {2'b0, b16.ex_rs};
      got[0].rt    = b32.ex_rt;           got[1].rt    = {2'b0, b16.ex_rt};
      got[0].rd    = b32.ex_rd;           got[1].rd    = {2'b0, b16.ex_rd};
      got[0].br    = b32.ex_branch;       got[1].br    = b16.ex_branch;
      got[0].mr    = b32.ex_mem_read;     got[1].mr    = b16.ex_mem_read;
      got[0].mw    = b32.ex_mem_write;    got[1].mw    = b16.ex_mem_write;
      got[0].m2r   = b32.ex_mem_to_reg;   got[1].m2r   = b16.ex_mem_to_reg;
      got[0].rdst  = b32.ex_reg_dst;      got[1].rdst  = b16.ex_reg_dst;
      got[0].rw    = b32.ex_reg_write;    got[1].rw    = b16.ex_reg_write;
      got[0].asrc  = b32.ex_alu_src;      got[1].asrc  = b16.ex_alu_src;
      got[0].op    = b32.ex_alu_op;       got[1].op    = b16.ex_alu_op;
      got[0].ill   = b32.ex_illegal;      got[1].ill   = b16.ex_illegal;
      got_stall[0] = b32.stall;           got_stall[1] = b16.stall;
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   task automatic cmp_ex(input int k);
      ex_t g, m;
      g = got[k];
      m = m_ex[k];
      chk($sformatf("c%0d_valid", k), {31'd0, g.valid}, {31'd0, m.valid});
      chk($sformatf("c%0d_data1", k), g.d1, m.d1);
      chk($sformatf("c%0d_data2", k), g.d2, m.d2);
      chk($sformatf("c%0d_imm", k), g.imm, m.imm);
      chk($sformatf("c%0d_addr", k), {17'd0, g.rs, g.rt, g.rd}, {17'd0, m.rs, m.rt, m.rd});
      chk($sformatf("c%0d_ctrl", k), {24'd0, g.br, g.mr, g.mw, g.m2r, g.rdst, g.rw, g.asrc, g.ill},
                                     {24'd0, m.br, m.mr, m.mw, m.m2r, m.rdst, m.rw, m.asrc, m.ill});
      chk($sformatf("c%0d_alu_op", k), {26'd0, g.op}, {26'd0, m.op});
      chk($sformatf("c%0d_stall", k), {31'd0, got_stall[k]}, {31'd0, m_hazard(k) && !flush});
   endtask

   always @(negedge clk) begin
      cmp_ex(0);
      cmp_ex(1);
   end

   // ---------------- driver tasks ----------------
   function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 1'b0;
      tick();
   endtask

   task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
      id_valid = 1'b0;
      wbw = 1'b1;
      wba = a;
      wbd = d;
      tick();
      wbw = 1'b0;
   endtask

   // Presents one instruction, holding it while stall is high (bounded).
   task automatic issue(input logic [31:0] i, output int stalls);
      logic s;
      id_valid = 1'b1;
      instr    = i;
      stalls   = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         s = b32.stall;
         @(posedge clk);
         #1;
         if (!s) return;
         stalls++;
      end
      n_cmp++;
      n_fail++;
      $display("FAIL issue_timeout instr=%h actual=stalled required=accepted", i);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; wbw = 1'b0;
      instr = 32'd0; wba = 5'd0; wbd = 32'd0;
      repeat (3) tick();
      chk("rst_ex_valid", {31'd0, b32.ex_valid}, 32'd0);
      chk("rst_stall", {31'd0, b32.stall}, 32'd0);
      chk("rst_data1", b32.ex_data1, 32'd0);
      rst_n = 1'b1;
      tick();

      wb_write(5'd5, 32'h0000_1234);
      issue(r_ins(5'd5, 5'd0, 5'd3, 6'h20), nst);
      chk("add_data1", b32.ex_data1, 32'h0000_1234);
      chk("add_data2", b32.ex_data2, 32'd0);
      chk("add_reg_dst", {31'd0, b32.ex_reg_dst}, 32'd1);
      chk("add_alu_op", {26'd0, b32.ex_alu_op}, 32'h20);
      chk("add_valid", {31'd0, b32.ex_valid}, 32'd1);
      chk("add16_data1", {16'd0, b16.ex_data1}, 32'h1234);

      wbw = 1'b1; wba = 5'd7; wbd = 32'hDEAD_BEEF;
      issue(r_ins(5'd7, 5'd0, 5'd1, 6'h21), nst);
      wbw = 1'b0;
      chk("bypass_data1", b32.ex_data1, 32'hDEAD_BEEF);
      chk("bypass16_data1", {16'd0, b16.ex_data1}, 32'h0000_BEEF);

      wb_write(5'd0, 32'hFFFF_FFFF);
      issue(r_ins(5'd0, 5'd0, 5'd2, 6'h20), nst);
      chk("r0_data1", b32.ex_data1, 32'd0);
      chk("r0_data2", b32.ex_data2, 32'd0);

      issue(i_ins(6'h08, 5'd1, 5'd2, 16'h8000), nst);
      chk("addi_imm", b32.ex_imm, 32'hFFFF_8000);
      chk("addi16_imm", {16'd0, b16.ex_imm}, 32'h0000_8000);
      issue(i_ins(6'h0D, 5'd1, 5'd2, 16'h8000), nst);
      chk("ori_imm", b32.ex_imm, 32'h0000_8000);
      issue(i_ins(6'h0C, 5'd1, 5'd2, 16'h00FF), nst);
      chk("andi_alu_op", {26'd0, b32.ex_alu_op}, 32'h24);
      chk("andi_imm", b32.ex_imm, 32'h0000_00FF);
      issue(i_ins(6'h04, 5'd1, 5'd2, 16'hFFFF), nst);
      chk("beq_alu_op", {26'd0, b32.ex_alu_op}, 32'h22);
      chk("beq_imm", b32.ex_imm, 32'hFFFF_FFFF);

      // load-use through rs, through rt, and the non-stalling variants
      issue(i_ins(6'h23, 5'd1, 5'd2, 16'h0004), nst);
      chk("lw_mem_read", {31'd0, b32.ex_mem_read}, 32'd1);
      issue(r_ins(5'd2, 5'd3, 5'd4, 6'h20), nst);
      chk("lu_rs_stalls", nst, 32'd1);
      chk("lu_rs_issued", {31'd0, b32.ex_valid}, 32'd1);
      issue(i_ins(6'h23, 5'd1, 5'd2, 16'h0008), nst);
      issue(r_ins(5'd3, 5'd2, 5'd4, 6'h22), nst);
      chk("lu_rt_stalls", nst, 32'd1);
      issue(i_ins(6'h23, 5'd1, 5'd2, 16'h0000), nst);
      issue(i_ins(6'h2B, 5'd1, 5'd2, 16'h0000), nst);
      chk("lu_sw_stalls", nst, 32'd1);
      issue(i_ins(6'h23, 5'd1, 5'd2, 16'h0000), nst);
      issue(i_ins(6'h08, 5'd1, 5'd2, 16'h0001), nst);
      chk("lu_addi_rt_stalls", nst, 32'd0);
      issue(i_ins(6'h23, 5'd1, 5'd0, 16'h0000), nst);
      issue(r_ins(5'd0, 5'd0, 5'd4, 6'h20), nst);
      chk("lu_r0_stalls", nst, 32'd0);

      // flush concurrent with a load-use hazard
      issue(i_ins(6'h23, 5'd1, 5'd2, 16'h0000), nst);
      instr = r_ins(5'd2, 5'd3, 5'd4, 6'h20);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", {31'd0, b32.stall}, 32'd0);
      tick();
      chk("flush_bubble", {31'd0, b32.ex_valid}, 32'd0);
      flush = 1'b0;
      idle();
      chk("idle_bubble", {31'd0, b32.ex_valid}, 32'd0);

      issue(i_ins(6'h3F, 5'd1, 5'd2, 16'h1234), nst);
      chk("ill_flag", {31'd0, b32.ex_illegal}, 32'd1);
      chk("ill_ctrl", {25'd0, b32.ex_branch, b32.ex_mem_read, b32.ex_mem_write,
          b32.ex_mem_to_reg, b32.ex_reg_dst, b32.ex_reg_write, b32.ex_alu_src}, 32'd0);
      chk("ill_alu_op", {26'd0, b32.ex_alu_op}, 32'd0);

      // 16-bit instance sees rs=13 as r5 after truncation to 3 bits
      issue(r_ins(5'd13, 5'd0, 5'd9, 6'h20), nst);
      chk("trunc16_rs", {29'd0, b16.ex_rs}, 32'd5);
      chk("trunc16_rd", {29'd0, b16.ex_rd}, 32'd1);
      chk("trunc16_data1", {16'd0, b16.ex_data1}, 32'h1234);
      chk("trunc32_data1", b32.ex_data1, 32'd0);

      // asynchronous reset mid-stream, then normal update after release
      issue(r_ins(5'd5, 5'd7, 5'd3, 6'h20), nst);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, b32.ex_valid}, 32'd0);
      chk("midrst16_valid", {31'd0, b16.ex_valid}, 32'd0);
      chk("midrst_data1", b32.ex_data1, 32'd0);
      tick();
      rst_n = 1'b1;
      issue(r_ins(5'd5, 5'd7, 5'd3, 6'h20), nst);
      chk("postrst_valid", {31'd0, b32.ex_valid}, 32'd1);
      chk("postrst_data1", b32.ex_data1, 32'd0);
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised decode stage with an integrated ID/EX pipeline register.
- Sits between the fetch stage and the execute stage of the pipelined core.
- Adds four things to the combinational decode: a register file with write-through bypass, selectable sign/zero immediate extension, load-use hazard detection with stall, and flush.
- All execute-facing outputs are registered.

Parameters:
- DATA_W, 32, width of register-file data and immediates after extension.
- NREGS, 32, number of architectural registers (power of 2, >=2). Register 0 is hardwired to zero. AW = log2(NREGS), at most 5 because the address fields are 5 bits wide.
- IMM_W, 16, width of the raw immediate field (instruccion[IMM_W-1:0]). IMM_W <= DATA_W.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  instruccion holds a valid instruction.
- instruccion  in  32  instruction word from fetch.
- flush  in  1  squash the instruction currently in decode (branch taken).
- wb_reg_write  in  1  writeback write enable.
- wb_addr  in  AW  writeback destination register.
- wb_data  in  DATA_W  writeback data.
- stall  out  1  combinational; fetch holds its PC and instruction while this is high.
- ex_valid  out  1  ID/EX entry is valid.
- ex_data1, ex_data2  out  DATA_W  register operands for rs and rt.
- ex_imm  out  DATA_W  extended immediate.
- ex_rs, ex_rt, ex_rd  out  AW  register address fields, for forwarding and destination mux.
- ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_dst, ex_reg_write, ex_alu_src  out  1 each  control bits.
- ex_alu_op  out  6  ALU operation code.
- ex_illegal  out  1  opcode not recognised.

Behaviour:
- Field extraction: opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0]. Address fields are truncated to AW bits.
- Register file, writes:
  - A write happens on the rising edge when wb_reg_write=1 and wb_addr!=0.
  - Writes to register 0 are ignored; register 0 always reads as 0.
- Register file, reads:
  - Reads are combinational.
  - Bypass rule: if wb_reg_write=1, wb_addr!=0 and wb_addr equals the read address, the read returns wb_data in the same cycle.
- Control decode, by opcode:
  - 0x00 R-type: reg_dst=1, reg_write=1, alu_op=funct.
  - 0x23 lw: mem_read=1, mem_to_reg=1, reg_write=1, alu_src=1, alu_op=0x20.
  - 0x2B sw: mem_write=1, alu_src=1, alu_op=0x20.
  - 0x04 beq: branch=1, alu_op=0x22.
  - 0x08 addi: reg_write=1, alu_src=1, alu_op=0x20, sign-extend.
  - 0x0C andi: reg_write=1, alu_src=1, alu_op=0x24, zero-extend.
  - 0x0D ori: reg_write=1, alu_src=1, alu_op=0x25, zero-extend.
  - Any other opcode: all control bits 0, alu_op=0, illegal=1.
- Immediate extension: zero-extend for andi/ori; sign-extend from bit IMM_W-1 for every other opcode.
- Hazard detection:
  - hazard = id_valid & ex_valid & ex_mem_read & (ex_rt!=0) & (ex_rt==rs | (ex_rt==rt & opcode uses rt as a source)).
  - rt is a source for R-type, sw and beq.
  - stall = hazard & ~flush.
- ID/EX register update on each rising edge, highest priority first:
  - (a) flush=1: load a bubble (ex_valid=0, all control bits 0, ex_illegal=0; data/address fields don't-care but driven 0).
  - (b) hazard: load a bubble. Fetch re-presents the same instruction next cycle. Stall lasts exactly one cycle per load-use pair.
  - (c) id_valid=0: load a bubble.
  - (d) otherwise: capture the decoded fields, operands (including the bypass) and controls, with ex_valid=1.
- Latency: one cycle from instruccion to the ex_* outputs.
- Reset while low:
  - All ex_* outputs = 0 and stall = 0 (no valid entry).
  - All registers = 0.
  - Deassertion mid-stream: the first edge after release follows the normal update rules.
- Simultaneous events: flush together with a hazard gives a bubble with stall=0. A writeback to the register being read in the same cycle delivers the new value through the bypass.

Test Plan:
- Reset then writes: rst_n low 3 cycles → all ex_* = 0, stall = 0. Release; write r5=0x0000_1234, then decode R-type add r3,r5,r0 → ex_data1=0x1234, ex_data2=0, ex_reg_dst=1, ex_alu_op=0x20, ex_valid=1 one cycle later.
- Bypass and r0: write r7=0xDEADBEEF in the same cycle that rs=7 is decoded → ex_data1=0xDEADBEEF. Write to r0 → reads of r0 stay 0.
- Immediate extension: addi with imm 0x8000 → ex_imm=0xFFFF8000. ori with imm 0x8000 → ex_imm=0x00008000. andi → alu_op=0x24.
- Load-use: lw r2 followed by add r4,r2,r3 → stall=1 for exactly one cycle, one bubble (ex_valid=0), then add issues. lw r2 followed by addi r4,r1 with rt=2 → no stall. lw r0 followed by a use of r0 → no stall.
- Flush: flush=1 concurrent with a load-use hazard → stall=0, ex_valid=0 next cycle. Illegal opcode 0x3F → ex_illegal=1, all control bits 0.
- Parameter sweep: DATA_W=16, NREGS=8 → sign extension fills to 16 bits, addresses truncate to 3 bits, rerun the scenarios above.
